// File: rtl/light_pkg.sv
// light_pkg: shared FSM states, stage lengths and latency for light_shade_seq
package light_pkg;
   typedef enum logic [2:0] {IDLE, EDGE, CROSS, DOT, NORM, SCALE, SEARCH, DONE} state_t;
   localparam int EDGE_CYC = 1;
   localparam int CROSS_CYC = 6;
   localparam int DOT_CYC = 3;
   localparam int NORM_CYC = 6;
   localparam int SCALE_CYC = 2;
   function automatic int search_cyc(int k);
      return k + 1;
   endfunction
   function automatic int latency(int k);
      return EDGE_CYC + CROSS_CYC + DOT_CYC + NORM_CYC + SCALE_CYC + search_cyc(k);
   endfunction
   function automatic int early_latency();
      return EDGE_CYC + CROSS_CYC + DOT_CYC;
   endfunction
   function automatic int sat_shade(int amb, int q, int w);
      int m;
      m = (1 << w) - 1;
      return amb + q > m ? m : amb + q;
   endfunction
endpackage

// File: rtl/light_shade_search.sv
// light_shade_search: bitwise search for the largest q with q^2*S <= d^2*2^(2K)
module light_shade_search #(
   parameter int K = 4,
   parameter int PW = 64,
   parameter int SW = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 en,
   input  logic [7:0]           step,
   input  logic signed [PW-1:0] prod,
   input  logic signed [SW-1:0] d2,
   output logic [2*K+1:0]       cand_sq,
   output logic [K:0]           q_nxt
);
   localparam int QW = K + 1;
   localparam int CW = 2 * K + 2;
   logic [QW-1:0] q, cand;
   logic [CW-1:0] qsq;
   logic [7:0] j;
   logic ok;
   // candidate squared by shift-and-add so the shared multiplier only forms cand^2*S
   always_comb begin
      j = 8'(K) - step;
      cand = q | (QW'(1) << j);
      cand_sq = qsq + (CW'(q) << (j + 8'd1)) + (CW'(1) << (j << 1));
      ok = $unsigned(prod) <= (PW'($unsigned(d2)) << (2 * K));
      q_nxt = en && ok ? cand : q;
   end
   // keep the candidate bit when its scaled square stays within d^2
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         q <= '0;
         qsq <= '0;
      end else if (clr) begin
         q <= '0;
         qsq <= '0;
      end else if (en && ok) begin
         q <= cand;
         qsq <= cand_sq;
      end
endmodule

// File: rtl/light_shade_seq.sv
// light_shade_seq: sequential Lambert shade of a triangle using one shared multiplier
module light_shade_seq import light_pkg::*; #(
   parameter int WII = 8,
   parameter int WIF = 8,
   parameter int SHADE_W = 6,
   parameter int AMBIENT = 8,
   parameter int FRAC_BITS = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic signed [WII+WIF-1:0]  inax, inay, inaz,
   input  logic signed [WII+WIF-1:0]  inbx, inby, inbz,
   input  logic signed [WII+WIF-1:0]  incx, incy, incz,
   input  logic signed [WII+WIF-1:0]  lx, ly, lz,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [SHADE_W-1:0]         out_shade,
   output logic                       out_backface,
   output logic                       out_degen
);
   localparam int W = WII + WIF;
   localparam int K = FRAC_BITS;
   localparam int EW = W + 1;
   localparam int NW = 2 * W + 3;
   localparam int DW = 3 * W + 5;
   localparam int LLW = 2 * W + 2;
   localparam int NNW = 4 * W + 8;
   localparam int SW = 6 * W + 8;
   localparam int PW = NNW + SW;
   state_t state, nxt;
   logic [7:0] cnt, len;
   logic [1:0] i, p1, p2, ci;
   logic last, accept, d_pos;
   logic signed [W-1:0] va [3], vb [3], vc [3], lv [3];
   logic signed [EW-1:0] ea [3], eb [3];
   logic signed [NW-1:0] n [3];
   logic signed [DW-1:0] d, d_nxt;
   logic signed [NNW-1:0] nn, ma;
   logic signed [LLW-1:0] ll;
   logic signed [SW-1:0] s, d2, mb;
   logic signed [PW-1:0] prod;
   logic [2*K+1:0] cand_sq;
   logic [K:0] q_nxt;
   // stage length, dot-product completion and cross-product operand indices
   always_comb begin
      len = state == CROSS ? 8'(CROSS_CYC) : state == DOT ? 8'(DOT_CYC) : state == NORM ? 8'(NORM_CYC) :
            state == SCALE ? 8'(SCALE_CYC) : state == SEARCH ? 8'(search_cyc(K)) : 8'(EDGE_CYC);
      last = cnt == len - 8'd1;
      accept = state == IDLE && in_valid && in_ready;
      d_nxt = cnt == '0 ? DW'(prod) : d + DW'(prod);
      d_pos = !d_nxt[DW-1] && |d_nxt;
      i = cnt[2:1];
      p1 = i == 2'd2 ? 2'd0 : i + 2'd1;
      p2 = i == 2'd0 ? 2'd2 : i - 2'd1;
      ci = cnt < 8'd3 ? cnt[1:0] : 2'(cnt - 8'd3);
   end
   // shared multiplier operand select, one product per cycle
   always_comb begin
      ma = '0;
      mb = '0;
      case (state)
         CROSS: begin
            ma = NNW'(cnt[0] ? ea[p2] : ea[p1]);
            mb = SW'(cnt[0] ? eb[p1] : eb[p2]);
         end
         DOT: begin
            ma = NNW'(n[ci]);
            mb = SW'(lv[ci]);
         end
         NORM: begin
            ma = cnt < 8'd3 ? NNW'(n[ci]) : NNW'(lv[ci]);
            mb = cnt < 8'd3 ? SW'(n[ci]) : SW'(lv[ci]);
         end
         SCALE: begin
            ma = cnt[0] ? NNW'(d) : nn;
            mb = cnt[0] ? SW'(d) : SW'(ll);
         end
         SEARCH: begin
            ma = NNW'(cand_sq);
            mb = s;
         end
         default: ;
      endcase
      prod = PW'(ma) * PW'(mb);
   end
   // state register and per-stage cycle counter
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
      end else begin
         state <= nxt;
         cnt <= nxt != state ? '0 : cnt + 8'd1;
      end
   // next-state sequencing, early exit when the light is behind the face
   always_comb begin
      nxt = state;
      case (state)
         IDLE: if (accept) nxt = EDGE;
         EDGE: if (last) nxt = CROSS;
         CROSS: if (last) nxt = DOT;
         DOT: if (last) nxt = d_pos ? NORM : DONE;
         NORM: if (last) nxt = SCALE;
         SCALE: if (last) nxt = SEARCH;
         SEARCH: if (last) nxt = DONE;
         DONE: if (out_ready) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end
   // handshake outputs; in_ready is held low while reset is asserted
   always_comb begin
      in_ready = state == IDLE && !rst;
      out_valid = state == DONE;
   end
   // datapath accumulation and result capture
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         va <= '{default: '0};
         vb <= '{default: '0};
         vc <= '{default: '0};
         lv <= '{default: '0};
         ea <= '{default: '0};
         eb <= '{default: '0};
         n <= '{default: '0};
         d <= '0;
         nn <= '0;
         ll <= '0;
         s <= '0;
         d2 <= '0;
         out_shade <= '0;
         out_backface <= 1'b0;
         out_degen <= 1'b0;
      end else begin
         if (accept) begin
            va <= '{inax, inay, inaz};
            vb <= '{inbx, inby, inbz};
            vc <= '{incx, incy, incz};
            lv <= '{lx, ly, lz};
         end
         if (state == EDGE)
            for (int j = 0; j < 3; j++) begin
               ea[j] <= EW'(vb[j]) - EW'(va[j]);
               eb[j] <= EW'(vc[j]) - EW'(va[j]);
            end
         if (state == CROSS) n[i] <= cnt[0] ? n[i] - NW'(prod) : NW'(prod);
         if (state == DOT) d <= d_nxt;
         if (state == NORM && cnt < 8'd3) nn <= cnt == '0 ? NNW'(prod) : nn + NNW'(prod);
         if (state == NORM && cnt >= 8'd3) ll <= cnt == 8'd3 ? LLW'(prod) : ll + LLW'(prod);
         if (state == SCALE && !cnt[0]) s <= SW'(prod);
         if (state == SCALE && cnt[0]) d2 <= SW'(prod);
         if (state == DOT && last && !d_pos) begin
            out_shade <= SHADE_W'(sat_shade(AMBIENT, 0, SHADE_W));
            out_backface <= 1'b1;
            out_degen <= n[0] == '0 && n[1] == '0 && n[2] == '0;
         end
         if (state == SEARCH && last) begin
            out_shade <= SHADE_W'(sat_shade(AMBIENT, int'(q_nxt), SHADE_W));
            out_backface <= 1'b0;
            out_degen <= 1'b0;
         end
      end
   light_shade_search #(.K(K), .PW(PW), .SW(SW)) u_search (
      .clk(clk),
      .rst(rst),
      .clr(accept),
      .en(state == SEARCH),
      .step(cnt),
      .prod(prod),
      .d2(d2),
      .cand_sq(cand_sq),
      .q_nxt(q_nxt)
   );
endmodule
